// File: rtl/alu_mult_ctrl_if.sv
// Request/response bundle between the execute stage and the mult sequencer.
// Signals: start, mcand, mplier (requester -> sequencer); busy, done, product (back).
interface alu_mult_ctrl_if;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [63:0] product;

  modport master (
    output start, mcand, mplier,
    input  busy, done, product
  );

  modport slave (
    input  start, mcand, mplier,
    output busy, done, product
  );
endinterface

// File: rtl/alu_mult_ctrl.sv
// Shift-and-add 32x32 unsigned multiply sequencer driving the shared ALU add port.
// Ports: clk, rst_n, mif (slave: start/mcand/mplier in, busy/done/product out),
// alu_a/alu_b/alu_op/alu_shamt to the ALU, alu_result/alu_carry back from it.
// Optional: define MULT_EARLY_EXIT_EN to finish once the remaining multiplier bits are zero.
module alu_mult_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_mult_ctrl_if.slave   mif,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   acc_hi_q;
  logic [WIDTH-1:0]   acc_lo_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [5:0]         cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] prod_q;

  logic               c;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_d;

  assign alu_a     = acc_hi_q;
  assign alu_b     = mcand_q;
  assign alu_op    = 4'b0001;
  assign alu_shamt = 5'd0;

  assign mif.busy    = busy_q;
  assign mif.done    = done_q;
  assign mif.product = prod_q;

  // The add carry becomes the new top bit, so nothing overflows.
  always_comb begin
    c   = 1'b0;
    sum = acc_hi_q;
    if (acc_lo_q[0]) begin
      c   = alu_carry;
      sum = alu_result;
    end
    acc_hi_d = {c, sum[WIDTH-1:1]};
    acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
  end

`ifdef MULT_EARLY_EXIT_EN
  logic               rest_zero;
  logic [2*WIDTH-1:0] early_p;

  // After k steps the low WIDTH-k bits of acc_lo are the unconsumed multiplier.
  always_comb begin
    rest_zero = ~|(acc_lo_q & ({WIDTH{1'b1}} >> cnt_q[4:0]));
    early_p   = {acc_hi_q, acc_lo_q} >> (7'd32 - {1'b0, cnt_q});
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mif.start) begin
            acc_hi_q <= '0;
            acc_lo_q <= mif.mplier;
            mcand_q  <= mif.mcand;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
`ifdef MULT_EARLY_EXIT_EN
          if (rest_zero) begin
            prod_q  <= early_p;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else
`endif
          begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
              prod_q  <= {acc_hi_d, acc_lo_d};
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_mult_ctrl.md
# alu_mult_ctrl

Multi-cycle shift-and-add multiply sequencer for KGP-RISC that owns one port of the shared 32-bit ALU. It drives the ALU with the add opcode, samples its result and carry flag each cycle, and accumulates a 64-bit unsigned product over 32 iterations. It sits beside the ALU in the execute stage and gives the core `mult`-class instructions a start/busy/done handshake.

## Interface
- `WIDTH`, 32: operand width; the product is 2×WIDTH. Only 32 is supported because the ALU is fixed at 32 bits.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request pulse; sampled only in IDLE.
- `mcand` input 32: multiplicand, unsigned; latched on accept.
- `mplier` input 32: multiplier, unsigned; latched on accept.
- `busy` output 1: high from the cycle after accept through the DONE cycle inclusive.
- `done` output 1: one-cycle pulse; `product` is valid from this cycle onward.
- `product` output 64: result register; holds its value until the next completion or reset.
- `alu_a` output 32: drives ALU `a`; equals `acc_hi`.
- `alu_b` output 32: drives ALU `b`; equals latched `mcand`.
- `alu_op` output 4: constant 4'b0001 (add).
- `alu_shamt` output 5: constant 0.
- `alu_result` input 32: ALU `result`; combinational, same cycle.
- `alu_carry` input 1: ALU `fCarry`; combinational, same cycle.

## Operation
- Internal state:
  - `acc_hi[31:0]`, `acc_lo[31:0]`, latched `mcand_r`.
  - `cnt[5:0]`.
  - FSM with states IDLE, CALC, DONE.
- IDLE, `start=1`:
  - `acc_hi←0`, `acc_lo←mplier`, `mcand_r←mcand`, `cnt←0`.
  - Go to CALC.
- CALC, each cycle:
  - If `acc_lo[0]=1`: `{c,sum} = {alu_carry, alu_result}`. Otherwise `c=0`, `sum=acc_hi`; the ALU output is ignored.
  - Update `{acc_hi,acc_lo} ← {c,sum,acc_lo} >> 1` and `cnt←cnt+1`.
  - When `cnt==31`, load `product` with the updated `{acc_hi,acc_lo}` and go to DONE.
- DONE:
  - `done=1` and `busy=1` for exactly one cycle, then IDLE.
  - `start` is ignored in DONE; requesters re-issue it in IDLE.
- `start` while busy is ignored. Changes to `mcand`/`mplier` after accept have no effect.
- Arithmetic is unsigned modulo 2^64. The carry out of the 32-bit add is the bit shifted into `acc_hi[31]`, so no overflow is lost.
- ALU ports are driven continuously, including in IDLE. They carry no side effects.

## Timing
- Reset (`rst_n=0`, asynchronous, any state):
  - State goes to IDLE.
  - `busy=0`, `done=0`, `product=0`.
  - `acc_hi`, `acc_lo`, `mcand_r`, `cnt` all cleared; `alu_a=0`, `alu_b=0`.
  - An in-flight operation is discarded; no `done` is produced for it.
- Accept occurs at edge E0, when IDLE and `start=1`.
- CALC iterations k=0..31 occur at edges E1..E32.
- `product` is loaded at E32. `done` is high between E32 and E33. Latency is therefore 32 cycles from the accept edge to `done`.
- The earliest next accept is at E34: IDLE is entered at E33, and `start` is sampled at E34.
- Combinational path per CALC cycle: `acc_hi` → ALU → `alu_result`/`alu_carry` → `acc_hi` D input. It must close within one cycle.

## Configuration
- `MULT_EARLY_EXIT_EN` defined:
  - In CALC, with k=`cnt`, if the unconsumed multiplier bits `acc_lo[31-k:0]` are all zero, the next edge goes straight to DONE.
  - That edge loads `product ← {acc_hi,acc_lo} >> (32-k)`.
  - The result is identical to the full run; latency is k+1 cycles.
- `MULT_EARLY_EXIT_EN` undefined:
  - Always 32 CALC cycles.
  - No zero-detect or barrel-shift logic is present.

## Test plan
- 12 × 10, macro off:
  - `start` at E0 → `busy=1` at E1.
  - `done` pulses exactly once between E32 and E33, with `product=64'd120`.
  - `busy=0` after E33.
- 0xFFFFFFFF × 0xFFFFFFFF → `product=64'hFFFFFFFE_00000001`. This exercises `alu_carry` on every iteration.
- Mid-operation changes, 7 × 9:
  - Pulse `start` with 3 × 3 at E5 and change `mcand`/`mplier` at E10.
  - Required: result is `product=63`, a single `done` at E32, and no second operation.
- Reset mid-operation, 1000 × 1000:
  - Assert `rst_n=0` asynchronously between E12 and E13.
  - Required: immediately `busy=0`, `done=0`, `product=0`.
  - After release, a fresh 5 × 6 gives `product=30` 32 cycles after its accept.
- Early exit, macro on:
  - 0x12345678 × 1 → `done` between E2 and E3, `product=64'h12345678`.
  - 0x12345678 × 0 → `done` between E1 and E2, `product=0`.
  - Macro off, same stimulus → `done` between E32 and E33, same product values.
- Back-to-back: hold `start=1` continuously with 2 × 3.
  - Required: accepts at E0 and E34.
  - Two `done` pulses, both with `product=6`.
